// File: rtl/status_shift_sequencer_if.sv
// Request/response bundle between the microinstruction decoder and the
// Am2904 shift sequencer. The decoder side is the master; the sequencer
// drives the status-unit controls and the completion handshake.
interface status_shift_sequencer_if #(
   parameter int CNT_W = 6
);
   // request side
   logic             start;
   logic [CNT_W-1:0] count;
   logic [4:0]       shift_code;
   logic [1:0]       cin_code;
   logic             stat_en;
   logic [5:0]       stat_code;
   logic             abort;
   // status-unit controls and completion
   logic [12:0]      I;
   logic             nSE;
   logic             nCEm;
   logic             nCEu;
   logic             busy;
   logic             done;
   logic             aborted;
   logic [CNT_W-1:0] steps_left;

   modport master (
      output start, count, shift_code, cin_code, stat_en, stat_code, abort,
      input  I, nSE, nCEm, nCEu, busy, done, aborted, steps_left
   );

   modport slave (
      input  start, count, shift_code, cin_code, stat_en, stat_code, abort,
      output I, nSE, nCEm, nCEu, busy, done, aborted, steps_left
   );
endinterface

// File: rtl/status_shift_sequencer.sv
// Multi-cycle shift controller for the Am2904 status and shift unit.
// Accepts one request of 0..2^CNT_W-1 single-bit shift steps, issues one
// step per cycle, optionally closes with a machine-status load, then pulses
// done. Every output is a flop loaded from the next-state decode, so inputs
// never reach outputs combinationally.
// Optional feature macro: SHIFT_OVR_ACCUM_EN -- each shift step also loads
// uSR with overflow retain (nCEu=0, I[5:0]=6'o06) so overflow accumulates.
module status_shift_sequencer #(
   parameter int CNT_W = 6
) (
   input logic                    clk,
   input logic                    nRESET,
   status_shift_sequencer_if.slave bus
);

`ifdef SHIFT_OVR_ACCUM_EN
   localparam logic [5:0] SHIFT_LO   = 6'o06;  // uSR load, overflow retain
   localparam logic       SHIFT_NCEU = 1'b0;
`else
   localparam logic [5:0] SHIFT_LO   = 6'o00;
   localparam logic       SHIFT_NCEU = 1'b1;
`endif

   typedef enum logic [1:0] {IDLE, SHIFT, STATUS, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] steps_left_q, steps_left_d;
   logic [4:0]       shift_code_q, shift_code_d;
   logic [1:0]       cin_code_q, cin_code_d;
   logic             stat_en_q, stat_en_d;
   logic [5:0]       stat_code_q, stat_code_d;
   logic             aborted_q, aborted_d;
   logic [12:0]      i_q, i_d;
   logic             nse_q, nse_d;
   logic             ncem_q, ncem_d;
   logic             nceu_q, nceu_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Next state, request latching and step counting.
   always_comb begin
      state_d      = state_q;
      steps_left_d = steps_left_q;
      shift_code_d = shift_code_q;
      cin_code_d   = cin_code_q;
      stat_en_d    = stat_en_q;
      stat_code_d  = stat_code_q;
      aborted_d    = aborted_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               shift_code_d = bus.shift_code;
               cin_code_d   = bus.cin_code;
               stat_en_d    = bus.stat_en;
               stat_code_d  = bus.stat_code;
               steps_left_d = bus.count;
               aborted_d    = 1'b0;
               if (bus.count != '0)  state_d = SHIFT;
               else if (bus.stat_en) state_d = STATUS;
               else                  state_d = DONE;
            end
         end
         SHIFT: begin
            // An aborted step is not counted, so steps_left keeps its value.
            if (bus.abort) begin
               aborted_d = 1'b1;
               state_d   = DONE;
            end else begin
               steps_left_d = steps_left_q - 1'b1;
               if (steps_left_q == CNT_W'(1))
                  state_d = stat_en_q ? STATUS : DONE;
            end
         end
         STATUS:  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control outputs decoded from the state being entered, then registered.
   always_comb begin
      i_d    = '0;
      nse_d  = 1'b1;
      ncem_d = 1'b1;
      nceu_d = 1'b1;
      busy_d = 1'b0;
      done_d = 1'b0;
      case (state_d)
         SHIFT: begin
            i_d    = {cin_code_d, shift_code_d, SHIFT_LO};
            nse_d  = 1'b0;
            nceu_d = SHIFT_NCEU;
            busy_d = 1'b1;
         end
         STATUS: begin
            i_d    = {7'b0, stat_code_d};
            ncem_d = 1'b0;
            busy_d = 1'b1;
         end
         DONE: begin
            done_d = 1'b1;
            busy_d = 1'b1;
         end
         default: ;
      endcase
   end

   // State, latched request and registered outputs; synchronous reset.
   always_ff @(posedge clk) begin
      if (!nRESET) begin
         state_q      <= IDLE;
         steps_left_q <= '0;
         shift_code_q <= '0;
         cin_code_q   <= '0;
         stat_en_q    <= 1'b0;
         stat_code_q  <= '0;
         aborted_q    <= 1'b0;
         i_q          <= '0;
         nse_q        <= 1'b1;
         ncem_q       <= 1'b1;
         nceu_q       <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         steps_left_q <= steps_left_d;
         shift_code_q <= shift_code_d;
         cin_code_q   <= cin_code_d;
         stat_en_q    <= stat_en_d;
         stat_code_q  <= stat_code_d;
         aborted_q    <= aborted_d;
         i_q          <= i_d;
         nse_q        <= nse_d;
         ncem_q       <= ncem_d;
         nceu_q       <= nceu_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign bus.I          = i_q;
   assign bus.nSE        = nse_q;
   assign bus.nCEm       = ncem_q;
   assign bus.nCEu       = nceu_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.aborted    = aborted_q;
   assign bus.steps_left = steps_left_q;

endmodule
